// File: rtl/seq_shift_right.sv
// Iterative right shifter: one bit position per clock, logical or arithmetic fill.
// Launched by a start pulse in IDLE; signals completion with a one-cycle done pulse.
module seq_shift_right #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [WIDTH-1:0]   Out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic               fill_mode;
  logic               fill;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fill reads the current MSB, which still holds the latched sign bit.
  assign fill = fill_mode & Out[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Out       <= '0;
      cnt       <= '0;
      fill_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            Out       <= In;
            cnt       <= shamt;
            fill_mode <= arith;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            Out <= {fill, Out[WIDTH-1:1]};
            cnt <= cnt - SHAMT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed bench for seq_shift_right: latency, result, busy/done framing,
// ignored restarts and synchronous reset behaviour.
module tb_seq_shift_right;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] In;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] Out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  seq_shift_right #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .In    (In),
    .shamt (shamt),
    .arith (arith),
    .Out   (Out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one operation and follow it to completion. inject>0 pulses start
  // (with In all ones) at edge k+inject; start_in_done pulses start at the DONE edge.
  task automatic run_op(input string tag, input logic [31:0] din, input logic [4:0] sa,
                        input logic ar, input logic [31:0] exp,
                        input int inject, input bit start_in_done);
    int cycles;
    int busy_bad;
    int extra_done;
    In = din; shamt = sa; arith = ar; start = 1'b1;
    tick();                                   // edge k
    start = 1'b0;
    In = ~din; shamt = ~sa; arith = ~ar;      // post-accept input changes must not matter
    cycles = 0;
    busy_bad = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy !== 1'b1) busy_bad++;
      if (inject > 0 && cycles + 1 == inject) begin
        start = 1'b1; In = '1;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cycles), 32'(sa) + 32'd1);
    check({tag, " busy_while_shifting"}, 32'(busy_bad), 32'd0);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " out"}, Out, exp);
    if (start_in_done) begin
      start = 1'b1; In = 32'h5555_5555; shamt = 5'd3;
    end
    tick();
    start = 1'b0;
    extra_done = 0;
    check({tag, " idle_after_done_busy"}, {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra_done++;
      tick();
    end
    check({tag, " no_second_done"}, 32'(extra_done), 32'd0);
    check({tag, " out_held"}, Out, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; In = 32'hFFFF_FFFF; shamt = 5'd3; arith = 1'b1;

    // Reset with start asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst out", Out, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst idle busy", {31'd0, busy}, 32'd0);

    run_op("inv_lsl2",   32'h0000_003C, 5'd2,  1'b0, 32'h0000_000F, 0, 1'b0);
    run_op("pat_lsr4",   32'hF0F0_F0F0, 5'd4,  1'b0, 32'h0F0F_0F0F, 0, 1'b0);
    run_op("pat_asr4",   32'hF0F0_F0F0, 5'd4,  1'b1, 32'hFF0F_0F0F, 0, 1'b0);
    run_op("shamt0",     32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 0, 1'b0);
    run_op("lsr31",      32'hAAAA_AAAA, 5'd31, 1'b0, 32'h0000_0001, 0, 1'b0);
    run_op("asr31",      32'hAAAA_AAAA, 5'd31, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("asr_pos",    32'h7FFF_FFFF, 5'd4,  1'b1, 32'h07FF_FFFF, 0, 1'b0);
    run_op("start_busy", 32'h0000_0100, 5'd8,  1'b0, 32'h0000_0001, 3, 1'b0);
    run_op("start_done", 32'h8000_0000, 5'd1,  1'b1, 32'hC000_0000, 0, 1'b1);

    // Reset in the middle of a 10-step shift
    In = 32'hDEAD_BEEF; shamt = 5'd10; arith = 1'b1; start = 1'b1;
    tick();                                   // edge k
    start = 1'b0;
    tick(); tick(); tick();                   // edges k+1..k+3
    check("mid busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();                                   // edge k+4
    check("mid_rst out", Out, 32'd0);
    check("mid_rst busy", {31'd0, busy}, 32'd0);
    check("mid_rst done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (done === 1'b1 || busy === 1'b1) seen++;
        tick();
      end
      check("mid_rst no_done", 32'(seen), 32'd0);
    end
    run_op("after_rst", 32'h8000_0001, 5'd3, 1'b0, 32'h1000_0000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
